imem_arbiter: RTL and testbench
===============================

Name: imem_arbiter

Overview:
- Shares the single-port instruction memory between two requesters: the fetch stage (PC-driven reads) and a program loader / debug port (reads and writes).
- Fetch has fixed priority. A starvation counter guarantees the loader a slot after STARVE_LIMIT consecutive denials.
- Produces the stall enable that holds the PC when fetch loses arbitration, and routes the 1-cycle-latency read data back to the winning requester.

Parameters:
- ADDR_WIDTH, 32, width of all address ports.
- DATA_WIDTH, 32, width of all data ports.
- STARVE_LIMIT, 4, consecutive denied loader cycles before a forced loader grant; legal range 1..15.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- fetch_req_i  input  1  fetch read request
- fetch_addr_i  input  ADDR_WIDTH  fetch byte address (PC)
- fetch_gnt_o  output  1  fetch granted this cycle
- fetch_rvalid_o  output  1  fetch read data valid
- fetch_rdata_o  output  DATA_WIDTH  fetch read data
- stall_c_o  output  1  enable to fetch stage: hold PC
- ld_req_i  input  1  loader request
- ld_we_i  input  1  loader write (1) / read (0)
- ld_addr_i  input  ADDR_WIDTH  loader byte address
- ld_wdata_i  input  DATA_WIDTH  loader write data
- ld_gnt_o  output  1  loader granted this cycle
- ld_rvalid_o  output  1  loader read data valid
- ld_rdata_o  output  DATA_WIDTH  loader read data
- mem_ren_o  output  1  memory read enable
- mem_wen_o  output  1  memory write enable
- mem_addr_o  output  ADDR_WIDTH  memory address
- mem_wdata_o  output  DATA_WIDTH  memory write data
- mem_rdata_i  input  DATA_WIDTH  memory read data, valid the cycle after ren

Behaviour:
- Clock and reset:
  - Single clock clk.
  - rst is synchronous and active-high.
  - All registers clear on the rising edge where rst=1.
- Reset values: state=S_NORM, starve_cnt=0, owner regs 0, fetch_rvalid_o=0, ld_rvalid_o=0.
  - Grant, stall and mem enables are combinational; they evaluate to 0 whenever rst=1.
- Grants are combinational, same cycle as the request:
  - S_NORM: fetch_req_i wins if asserted; otherwise ld_req_i wins.
  - S_FORCE: ld_req_i wins regardless of fetch_req_i.
- stall_c_o = fetch_req_i & ~fetch_gnt_o.
- Memory mux when fetch wins:
  - mem_addr_o=fetch_addr_i, mem_ren_o=1, mem_wen_o=0.
- Memory mux when loader wins:
  - mem_addr_o=ld_addr_i, mem_wdata_o=ld_wdata_i.
  - mem_wen_o=ld_we_i, mem_ren_o=~ld_we_i.
- Memory mux when no grant:
  - mem_ren_o=mem_wen_o=0, mem_addr_o=fetch_addr_i, mem_wdata_o=0.
- Address handling: addresses pass through unchanged. Alignment and range are the requester's responsibility.
- Read response:
  - Registered owner bits capture the granted reads.
  - fetch_rvalid_o=1 exactly one cycle after a fetch grant.
  - ld_rvalid_o=1 exactly one cycle after a loader read grant. A loader write produces no rvalid.
  - fetch_rdata_o and ld_rdata_o are both driven from mem_rdata_i. Each is meaningful only while its rvalid is high.
- Starvation counter (4-bit):
  - Increments each cycle ld_req_i=1 and ld_gnt_o=0.
  - Clears on any loader grant or when ld_req_i=0.
  - Saturates at 15.
- State machine:
  - S_NORM -> S_FORCE when the registered counter value reaches STARVE_LIMIT.
  - S_FORCE -> S_NORM after one loader grant, or immediately if ld_req_i drops (no grant issued).
  - S_FORCE lasts at most one loader transaction.
- Simultaneous requests in S_NORM: fetch wins and the loader counter increments.
- Reset asserted mid-transaction: any pending rvalid is suppressed on the next cycle, and state returns to S_NORM.

Optional Feature:
- Macro: IMEM_ARBITER_STATS_EN.
- Defined: adds outputs stat_fetch_gnt_o, stat_ld_gnt_o and stat_stall_o (32-bit each). They count fetch grants, loader grants and stall_c_o cycles. Counters wrap at 2^32 and clear on rst.
- Undefined: these ports and counters do not exist. Arbitration behaviour is identical either way.

Test Plan:
- Only fetch_req_i=1, addresses 0x0,0x4,0x8 -> fetch_gnt_o=1 and stall_c_o=0 each cycle; fetch_rvalid_o=1 one cycle later with mem_rdata_i forwarded.
- Loader write alone (ld_we_i=1, addr 0x10, data 0xDEADBEEF) -> ld_gnt_o=1, mem_wen_o=1, mem_addr_o=0x10; no ld_rvalid_o on the following cycle.
- fetch_req_i and ld_req_i held high continuously, STARVE_LIMIT=4:
  - Fetch granted 4 cycles, then loader granted for 1 cycle with stall_c_o=1.
  - Pattern repeats with period 5.
- Loader read at 0x20 while fetch idle -> ld_rvalid_o=1 next cycle, fetch_rvalid_o=0.
- Enter S_FORCE, then assert rst on the grant cycle -> next cycle all rvalid=0, state S_NORM, starve_cnt=0, fetch wins a simultaneous request.
- With IMEM_ARBITER_STATS_EN, run the contended scenario for 10 cycles -> stat_fetch_gnt_o=8, stat_ld_gnt_o=2, stat_stall_o=2.

Source files
------------

// File: rtl/imem_arbiter.sv
// Arbitrates the single-port instruction memory between fetch (fixed priority) and the loader/debug port,
// with a starvation counter forcing a loader slot. Optional statistics counters under IMEM_ARBITER_STATS_EN.
module imem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req_i,
  input  logic [ADDR_WIDTH-1:0] fetch_addr_i,
  output logic                  fetch_gnt_o,
  output logic                  fetch_rvalid_o,
  output logic [DATA_WIDTH-1:0] fetch_rdata_o,
  output logic                  stall_c_o,
  input  logic                  ld_req_i,
  input  logic                  ld_we_i,
  input  logic [ADDR_WIDTH-1:0] ld_addr_i,
  input  logic [DATA_WIDTH-1:0] ld_wdata_i,
  output logic                  ld_gnt_o,
  output logic                  ld_rvalid_o,
  output logic [DATA_WIDTH-1:0] ld_rdata_o,
  output logic                  mem_ren_o,
  output logic                  mem_wen_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
`ifdef IMEM_ARBITER_STATS_EN
  ,
  output logic [31:0]           stat_fetch_gnt_o,
  output logic [31:0]           stat_ld_gnt_o,
  output logic [31:0]           stat_stall_o
`endif
);

  typedef enum logic {S_NORM = 1'b0, S_FORCE = 1'b1} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_starve_cnt;
  logic [3:0] w_cnt_nxt;
  logic       r_fetch_own_p1;
  logic       r_ld_own_p1;
  logic       w_fetch_gnt;
  logic       w_ld_gnt;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // In S_FORCE a present loader request pre-empts fetch; an idle loader leaves the slot to fetch.
  always_comb begin
    w_fetch_gnt = 1'b0;
    w_ld_gnt    = 1'b0;
    if (!rst) begin
      if (r_state == S_FORCE && ld_req_i) begin
        w_ld_gnt = 1'b1;
      end else if (fetch_req_i) begin
        w_fetch_gnt = 1'b1;
      end else if (ld_req_i) begin
        w_ld_gnt = 1'b1;
      end
    end
  end

  assign fetch_gnt_o = w_fetch_gnt;
  assign ld_gnt_o    = w_ld_gnt;
  assign stall_c_o   = ~rst & fetch_req_i & ~w_fetch_gnt;

  always_comb begin
    mem_ren_o   = 1'b0;
    mem_wen_o   = 1'b0;
    mem_addr_o  = fetch_addr_i;
    mem_wdata_o = '0;
    if (w_fetch_gnt) begin
      mem_ren_o = 1'b1;
    end else if (w_ld_gnt) begin
      mem_addr_o  = ld_addr_i;
      mem_wdata_o = ld_wdata_i;
      mem_wen_o   = ld_we_i;
      mem_ren_o   = ~ld_we_i;
    end
  end

  assign w_cnt_nxt = (ld_req_i && !w_ld_gnt) ? sat_inc(r_starve_cnt) : 4'd0;

  // Counter and state update on the same edge, so the loader wins the cycle the count hits the limit.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_NORM:  if (w_cnt_nxt >= LIMIT) w_state_nxt = S_FORCE;
      S_FORCE: w_state_nxt = S_NORM;
      default: w_state_nxt = S_NORM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_NORM;
      r_starve_cnt <= 4'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_cnt_nxt;
    end
  end

  // Stage p1: memory returns read data one cycle after the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_own_p1 <= 1'b0;
      r_ld_own_p1    <= 1'b0;
    end else begin
      r_fetch_own_p1 <= w_fetch_gnt;
      r_ld_own_p1    <= w_ld_gnt & ~ld_we_i;
    end
  end

  assign fetch_rvalid_o = r_fetch_own_p1;
  assign ld_rvalid_o    = r_ld_own_p1;
  assign fetch_rdata_o  = mem_rdata_i;
  assign ld_rdata_o     = mem_rdata_i;

`ifdef IMEM_ARBITER_STATS_EN
  logic [31:0] r_stat_fetch;
  logic [31:0] r_stat_ld;
  logic [31:0] r_stat_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_fetch <= '0;
      r_stat_ld    <= '0;
      r_stat_stall <= '0;
    end else begin
      r_stat_fetch <= r_stat_fetch + {31'd0, w_fetch_gnt};
      r_stat_ld    <= r_stat_ld + {31'd0, w_ld_gnt};
      r_stat_stall <= r_stat_stall + {31'd0, stall_c_o};
    end
  end

  assign stat_fetch_gnt_o = r_stat_fetch;
  assign stat_ld_gnt_o    = r_stat_ld;
  assign stat_stall_o     = r_stat_stall;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter; memory model returns (addr ^ 0xCAFE0000) one cycle after ren.
`timescale 1ns/1ps
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req_i;
  logic [31:0] fetch_addr_i;
  logic        fetch_gnt_o;
  logic        fetch_rvalid_o;
  logic [31:0] fetch_rdata_o;
  logic        stall_c_o;
  logic        ld_req_i;
  logic        ld_we_i;
  logic [31:0] ld_addr_i;
  logic [31:0] ld_wdata_i;
  logic        ld_gnt_o;
  logic        ld_rvalid_o;
  logic [31:0] ld_rdata_o;
  logic        mem_ren_o;
  logic        mem_wen_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
`ifdef IMEM_ARBITER_STATS_EN
  logic [31:0] stat_fetch_gnt_o;
  logic [31:0] stat_ld_gnt_o;
  logic [31:0] stat_stall_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i), .fetch_gnt_o(fetch_gnt_o),
    .fetch_rvalid_o(fetch_rvalid_o), .fetch_rdata_o(fetch_rdata_o), .stall_c_o(stall_c_o),
    .ld_req_i(ld_req_i), .ld_we_i(ld_we_i), .ld_addr_i(ld_addr_i), .ld_wdata_i(ld_wdata_i),
    .ld_gnt_o(ld_gnt_o), .ld_rvalid_o(ld_rvalid_o), .ld_rdata_o(ld_rdata_o),
    .mem_ren_o(mem_ren_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
`ifdef IMEM_ARBITER_STATS_EN
    , .stat_fetch_gnt_o(stat_fetch_gnt_o), .stat_ld_gnt_o(stat_ld_gnt_o), .stat_stall_o(stat_stall_o)
`endif
  );

  always @(posedge clk) begin
    if (mem_ren_o) mem_rdata_i <= mem_addr_o ^ 32'hCAFE0000;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_req_i = 1'b1; ld_req_i = 1'b1; ld_we_i = 1'b1;
    #1;
    checks++; if (fetch_gnt_o !== 1'b0) begin errors++; $display("FAIL rst_fetch_gnt got %b want 0", fetch_gnt_o); end
    checks++; if (ld_gnt_o !== 1'b0) begin errors++; $display("FAIL rst_ld_gnt got %b want 0", ld_gnt_o); end
    checks++; if (stall_c_o !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", stall_c_o); end
    checks++; if ({mem_ren_o, mem_wen_o} !== 2'b00) begin errors++; $display("FAIL rst_mem_en got %b want 00", {mem_ren_o, mem_wen_o}); end
    tick();
    checks++; if ({fetch_rvalid_o, ld_rvalid_o} !== 2'b00) begin errors++; $display("FAIL rst_rvalid got %b want 00", {fetch_rvalid_o, ld_rvalid_o}); end
    rst = 1'b0; fetch_req_i = 1'b0; ld_req_i = 1'b0; ld_we_i = 1'b0;
    tick();
  endtask

  task automatic test_fetch_only();
    logic [31:0] exp_data [3];
    exp_data[0] = 32'hCAFE0000; exp_data[1] = 32'hCAFE0004; exp_data[2] = 32'hCAFE0008;
    for (int i = 0; i < 3; i++) begin
      fetch_req_i = 1'b1; fetch_addr_i = 32'(4 * i);
      #1;
      checks++; if (fetch_gnt_o !== 1'b1) begin errors++; $display("FAIL fetch_gnt[%0d] got %b want 1", i, fetch_gnt_o); end
      checks++; if (stall_c_o !== 1'b0) begin errors++; $display("FAIL fetch_stall[%0d] got %b want 0", i, stall_c_o); end
      checks++; if (mem_addr_o !== 32'(4 * i) || mem_ren_o !== 1'b1) begin errors++; $display("FAIL fetch_mem[%0d] got addr %h ren %b want %h 1", i, mem_addr_o, mem_ren_o, 4 * i); end
      tick();
      checks++; if (fetch_rvalid_o !== 1'b1 || fetch_rdata_o !== exp_data[i]) begin errors++; $display("FAIL fetch_rdata[%0d] got %b %h want 1 %h", i, fetch_rvalid_o, fetch_rdata_o, exp_data[i]); end
    end
    fetch_req_i = 1'b0;
    tick();
    checks++; if (fetch_rvalid_o !== 1'b0) begin errors++; $display("FAIL fetch_rvalid_idle got %b want 0", fetch_rvalid_o); end
  endtask

  task automatic test_ld_write();
    ld_req_i = 1'b1; ld_we_i = 1'b1; ld_addr_i = 32'h10; ld_wdata_i = 32'hDEADBEEF;
    #1;
    checks++; if (ld_gnt_o !== 1'b1) begin errors++; $display("FAIL ldw_gnt got %b want 1", ld_gnt_o); end
    checks++; if ({mem_wen_o, mem_ren_o} !== 2'b10) begin errors++; $display("FAIL ldw_en got %b want 10", {mem_wen_o, mem_ren_o}); end
    checks++; if (mem_addr_o !== 32'h10 || mem_wdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL ldw_bus got %h %h want 00000010 deadbeef", mem_addr_o, mem_wdata_o); end
    tick();
    ld_req_i = 1'b0; ld_we_i = 1'b0;
    #1;
    checks++; if (ld_rvalid_o !== 1'b0) begin errors++; $display("FAIL ldw_rvalid got %b want 0", ld_rvalid_o); end
    tick();
  endtask

  task automatic test_ld_read();
    fetch_req_i = 1'b0; ld_req_i = 1'b1; ld_we_i = 1'b0; ld_addr_i = 32'h20;
    #1;
    checks++; if (ld_gnt_o !== 1'b1 || mem_ren_o !== 1'b1 || mem_addr_o !== 32'h20) begin errors++; $display("FAIL ldr_gnt got %b %b %h want 1 1 00000020", ld_gnt_o, mem_ren_o, mem_addr_o); end
    tick();
    ld_req_i = 1'b0;
    #1;
    checks++; if (ld_rvalid_o !== 1'b1 || fetch_rvalid_o !== 1'b0) begin errors++; $display("FAIL ldr_rvalid got ld %b fetch %b want 1 0", ld_rvalid_o, fetch_rvalid_o); end
    checks++; if (ld_rdata_o !== 32'hCAFE0020) begin errors++; $display("FAIL ldr_rdata got %h want cafe0020", ld_rdata_o); end
    tick();
  endtask

  task automatic test_starve_clear();
    fetch_req_i = 1'b1; fetch_addr_i = 32'h200; ld_req_i = 1'b1; ld_we_i = 1'b0; ld_addr_i = 32'h44;
    for (int i = 0; i < 3; i++) tick();
    ld_req_i = 1'b0;
    tick();
    ld_req_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (ld_gnt_o !== 1'b0 || fetch_gnt_o !== 1'b1) begin errors++; $display("FAIL clr_fetch[%0d] got ld %b fetch %b want 0 1", i, ld_gnt_o, fetch_gnt_o); end
      tick();
    end
    #1;
    checks++; if (ld_gnt_o !== 1'b1 || stall_c_o !== 1'b1) begin errors++; $display("FAIL clr_force got ld %b stall %b want 1 1", ld_gnt_o, stall_c_o); end
    fetch_req_i = 1'b0; ld_req_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_force_reset();
    fetch_req_i = 1'b1; fetch_addr_i = 32'h300; ld_req_i = 1'b1; ld_we_i = 1'b0; ld_addr_i = 32'h48;
    for (int i = 0; i < 4; i++) tick();
    #1;
    checks++; if (ld_gnt_o !== 1'b1 || stall_c_o !== 1'b1) begin errors++; $display("FAIL frc_enter got ld %b stall %b want 1 1", ld_gnt_o, stall_c_o); end
    rst = 1'b1;
    #1;
    checks++; if ({fetch_gnt_o, ld_gnt_o} !== 2'b00) begin errors++; $display("FAIL frc_rst_gnt got %b want 00", {fetch_gnt_o, ld_gnt_o}); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if ({fetch_rvalid_o, ld_rvalid_o} !== 2'b00) begin errors++; $display("FAIL frc_rvalid got %b want 00", {fetch_rvalid_o, ld_rvalid_o}); end
    checks++; if (fetch_gnt_o !== 1'b1 || ld_gnt_o !== 1'b0) begin errors++; $display("FAIL frc_norm got fetch %b ld %b want 1 0", fetch_gnt_o, ld_gnt_o); end
    for (int i = 0; i < 4; i++) tick();
    #1;
    checks++; if (ld_gnt_o !== 1'b1) begin errors++; $display("FAIL frc_cnt_clear got ld %b want 1", ld_gnt_o); end
    fetch_req_i = 1'b0; ld_req_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_contended();
    logic [9:0] exp_ld;
    exp_ld = 10'b1000010000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fetch_req_i = 1'b1; fetch_addr_i = 32'h100; ld_req_i = 1'b1; ld_we_i = 1'b0; ld_addr_i = 32'h40;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (ld_gnt_o !== exp_ld[i] || fetch_gnt_o !== ~exp_ld[i] || stall_c_o !== exp_ld[i]) begin
        errors++; $display("FAIL cont_gnt[%0d] got ld %b fetch %b stall %b want ld %b", i, ld_gnt_o, fetch_gnt_o, stall_c_o, exp_ld[i]);
      end
      checks++; if (mem_addr_o !== (exp_ld[i] ? 32'h40 : 32'h100)) begin errors++; $display("FAIL cont_addr[%0d] got %h", i, mem_addr_o); end
      if (i > 0) begin
        checks++; if (ld_rvalid_o !== exp_ld[i-1] || fetch_rvalid_o !== ~exp_ld[i-1]) begin
          errors++; $display("FAIL cont_rvalid[%0d] got ld %b fetch %b want ld %b", i, ld_rvalid_o, fetch_rvalid_o, exp_ld[i-1]);
        end
      end
      tick();
    end
`ifdef IMEM_ARBITER_STATS_EN
    checks++; if (stat_fetch_gnt_o !== 32'd8) begin errors++; $display("FAIL stat_fetch got %0d want 8", stat_fetch_gnt_o); end
    checks++; if (stat_ld_gnt_o !== 32'd2) begin errors++; $display("FAIL stat_ld got %0d want 2", stat_ld_gnt_o); end
    checks++; if (stat_stall_o !== 32'd2) begin errors++; $display("FAIL stat_stall got %0d want 2", stat_stall_o); end
`endif
    fetch_req_i = 1'b0; ld_req_i = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; fetch_req_i = 1'b0; fetch_addr_i = '0; ld_req_i = 1'b0; ld_we_i = 1'b0;
    ld_addr_i = '0; ld_wdata_i = '0; mem_rdata_i = '0;
    tick();
    test_reset();
    test_fetch_only();
    test_ld_write();
    test_ld_read();
    test_starve_clear();
    test_force_reset();
    test_contended();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached without completing");
    $fatal(1);
  end

endmodule
